// File: rtl/wave_capture_trig.sv
// Triggered waveform capture: waits for a hysteresis-qualified edge (or timeout),
// writes one decimated frame of offset-binary samples, then swaps RAM halves when idle.
module wave_capture_trig #(
    parameter int SAMPLE_WIDTH  = 18,
    parameter int DISP_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 8,
    parameter int DECIM_WIDTH   = 4,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     new_sample_ready,
    input  logic [SAMPLE_WIDTH-1:0]  new_sample_in,
    input  logic                     wave_display_idle,
    input  logic                     trig_falling,
    input  logic [SAMPLE_WIDTH-1:0]  trig_level,
    input  logic [SAMPLE_WIDTH-1:0]  trig_hyst,
    input  logic [DECIM_WIDTH-1:0]   decim,
    input  logic                     auto_en,
    input  logic [TIMEOUT_WIDTH-1:0] auto_timeout,
    output logic [ADDR_WIDTH:0]      write_address,
    output logic                     write_enable,
    output logic [DISP_WIDTH-1:0]    write_sample,
    output logic                     read_index,
    output logic                     frame_done,
    output logic                     auto_triggered
);

    typedef enum logic [1:0] {ARMED, ACTIVE, WAITING} state_t;

    // Two guard bits keep level +/- an unsigned full-range hysteresis exact.
    localparam int TW = SAMPLE_WIDTH + 2;
    localparam logic [DISP_WIDTH-1:0] MSB_FLIP = DISP_WIDTH'(1) << (DISP_WIDTH - 1);

    state_t                   state_q, state_d;
    logic                     load_q;
    logic                     cfg_falling_q, cfg_falling_d;
    logic [SAMPLE_WIDTH-1:0]  cfg_level_q, cfg_level_d;
    logic [SAMPLE_WIDTH-1:0]  cfg_hyst_q, cfg_hyst_d;
    logic [DECIM_WIDTH-1:0]   cfg_decim_q, cfg_decim_d;
    logic                     cfg_auto_en_q, cfg_auto_en_d;
    logic [TIMEOUT_WIDTH-1:0] cfg_timeout_q, cfg_timeout_d;
    logic [ADDR_WIDTH-1:0]    idx_q, idx_d;
    logic [DECIM_WIDTH-1:0]   dcnt_q, dcnt_d;
    logic [TIMEOUT_WIDTH-1:0] tcnt_q, tcnt_d;
    logic                     primed_q, primed_d;
    logic                     auto_q, auto_d;
    logic                     rd_q, rd_d;
    logic                     we_q, we_d;
    logic [ADDR_WIDTH:0]      waddr_q, waddr_d;
    logic [DISP_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     fd_q, fd_d;

    logic                     eff_falling;
    logic [SAMPLE_WIDTH-1:0]  eff_level;
    logic [SAMPLE_WIDTH-1:0]  eff_hyst;
    logic [DECIM_WIDTH-1:0]   eff_decim;
    logic                     eff_auto_en;
    logic [TIMEOUT_WIDTH-1:0] eff_timeout;
    logic signed [TW-1:0]     smp_x, lvl_x, hyst_x, lo_x, hi_x;
    logic [DISP_WIDTH-1:0]    disp;
    logic                     real_hit, timeout_hit, prime_hit;

    // On the first cycle out of reset the ports are used directly while being latched.
    always_comb begin
        eff_falling = load_q ? trig_falling : cfg_falling_q;
        eff_level   = load_q ? trig_level   : cfg_level_q;
        eff_hyst    = load_q ? trig_hyst    : cfg_hyst_q;
        eff_decim   = load_q ? decim        : cfg_decim_q;
        eff_auto_en = load_q ? auto_en      : cfg_auto_en_q;
        eff_timeout = load_q ? auto_timeout : cfg_timeout_q;
    end

    always_comb begin
        smp_x  = {{2{new_sample_in[SAMPLE_WIDTH-1]}}, new_sample_in};
        lvl_x  = {{2{eff_level[SAMPLE_WIDTH-1]}}, eff_level};
        hyst_x = {2'b00, eff_hyst};
        lo_x   = lvl_x - hyst_x;
        hi_x   = lvl_x + hyst_x;
        disp   = new_sample_in[SAMPLE_WIDTH-1 -: DISP_WIDTH] ^ MSB_FLIP;
        real_hit    = primed_q && (eff_falling ? (smp_x <= lvl_x) : (smp_x >= lvl_x));
        timeout_hit = eff_auto_en && (tcnt_q == eff_timeout);
        prime_hit   = eff_falling ? (smp_x > hi_x) : (smp_x < lo_x);
    end

    always_comb begin
        state_d       = state_q;
        cfg_falling_d = eff_falling;
        cfg_level_d   = eff_level;
        cfg_hyst_d    = eff_hyst;
        cfg_decim_d   = eff_decim;
        cfg_auto_en_d = eff_auto_en;
        cfg_timeout_d = eff_timeout;
        idx_d         = idx_q;
        dcnt_d        = dcnt_q;
        tcnt_d        = tcnt_q;
        primed_d      = primed_q;
        auto_d        = auto_q;
        rd_d          = rd_q;
        we_d          = 1'b0;
        waddr_d       = waddr_q;
        wdata_d       = wdata_q;
        fd_d          = 1'b0;

        case (state_q)
            ARMED: begin
                if (new_sample_ready) begin
                    if (real_hit || timeout_hit) begin
                        we_d     = 1'b1;
                        waddr_d  = {~rd_q, {ADDR_WIDTH{1'b0}}};
                        wdata_d  = disp;
                        auto_d   = ~real_hit;
                        state_d  = ACTIVE;
                        idx_d    = ADDR_WIDTH'(1);
                        dcnt_d   = '0;
                        primed_d = 1'b0;
                        tcnt_d   = '0;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                        if (prime_hit) primed_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (new_sample_ready) begin
                    if (dcnt_q == eff_decim) begin
                        we_d    = 1'b1;
                        waddr_d = {~rd_q, idx_q};
                        wdata_d = disp;
                        idx_d   = idx_q + 1'b1;
                        dcnt_d  = '0;
                        if (idx_q == {ADDR_WIDTH{1'b1}}) begin
                            fd_d    = 1'b1;
                            state_d = WAITING;
                        end
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
            end
            WAITING: begin
                if (wave_display_idle) begin
                    rd_d          = ~rd_q;
                    state_d       = ARMED;
                    primed_d      = 1'b0;
                    cfg_falling_d = trig_falling;
                    cfg_level_d   = trig_level;
                    cfg_hyst_d    = trig_hyst;
                    cfg_decim_d   = decim;
                    cfg_auto_en_d = auto_en;
                    cfg_timeout_d = auto_timeout;
                end
            end
            default: state_d = ARMED;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ARMED;
            load_q        <= 1'b1;
            cfg_falling_q <= 1'b0;
            cfg_level_q   <= '0;
            cfg_hyst_q    <= '0;
            cfg_decim_q   <= '0;
            cfg_auto_en_q <= 1'b0;
            cfg_timeout_q <= '0;
            idx_q         <= '0;
            dcnt_q        <= '0;
            tcnt_q        <= '0;
            primed_q      <= 1'b0;
            auto_q        <= 1'b0;
            rd_q          <= 1'b0;
            we_q          <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            fd_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_q        <= 1'b0;
            cfg_falling_q <= cfg_falling_d;
            cfg_level_q   <= cfg_level_d;
            cfg_hyst_q    <= cfg_hyst_d;
            cfg_decim_q   <= cfg_decim_d;
            cfg_auto_en_q <= cfg_auto_en_d;
            cfg_timeout_q <= cfg_timeout_d;
            idx_q         <= idx_d;
            dcnt_q        <= dcnt_d;
            tcnt_q        <= tcnt_d;
            primed_q      <= primed_d;
            auto_q        <= auto_d;
            rd_q          <= rd_d;
            we_q          <= we_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            fd_q          <= fd_d;
        end
    end

    assign write_address  = waddr_q;
    assign write_enable   = we_q;
    assign write_sample   = wdata_q;
    assign read_index     = rd_q;
    assign frame_done     = fd_q;
    assign auto_triggered = auto_q;

endmodule

// File: tb/tb_wave_capture_trig.sv
// Randomised bench for wave_capture_trig against a frame-level reference model
// (trigger rules, modulo decimation, write counts) plus directed scenario checks.
module tb_wave_capture_trig;

    localparam int SW = 18;
    localparam int NF = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_sample_ready;
    logic [17:0] new_sample_in;
    logic        wave_display_idle;
    logic        trig_falling;
    logic [17:0] trig_level;
    logic [17:0] trig_hyst;
    logic [3:0]  decim;
    logic        auto_en;
    logic [15:0] auto_timeout;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;
    logic        frame_done;
    logic        auto_triggered;

    wave_capture_trig #(
        .SAMPLE_WIDTH (18),
        .DISP_WIDTH   (8),
        .ADDR_WIDTH   (8),
        .DECIM_WIDTH  (4),
        .TIMEOUT_WIDTH(16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .new_sample_ready (new_sample_ready),
        .new_sample_in    (new_sample_in),
        .wave_display_idle(wave_display_idle),
        .trig_falling     (trig_falling),
        .trig_level       (trig_level),
        .trig_hyst        (trig_hyst),
        .decim            (decim),
        .auto_en          (auto_en),
        .auto_timeout     (auto_timeout),
        .write_address    (write_address),
        .write_enable     (write_enable),
        .write_sample     (write_sample),
        .read_index       (read_index),
        .frame_done       (frame_done),
        .auto_triggered   (auto_triggered)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: m_written = -1 while waiting for a trigger, 1..NF-1 while
    // capturing, NF once the frame is complete and the swap is pending.
    int       m_written, m_since, m_tc;
    bit       m_rd, m_primed, m_auto, m_load;
    bit [8:0] m_addr;
    bit [7:0] m_data;
    bit       c_fall, c_aen;
    int       c_lvl, c_hyst, c_dec, c_to;
    bit       e_we, e_fd;
    int       obs_writes, trig_strobes;

    function automatic void model_reset();
        m_written = -1; m_since = 0; m_tc = 0;
        m_rd = 0; m_primed = 0; m_auto = 0; m_load = 1;
        m_addr = '0; m_data = '0;
        e_we = 0; e_fd = 0;
    endfunction

    function automatic void model_latch();
        c_fall = trig_falling;
        c_lvl  = int'($signed(trig_level));
        c_hyst = int'(trig_hyst);
        c_dec  = int'(decim);
        c_aen  = auto_en;
        c_to   = int'(auto_timeout);
    endfunction

    function automatic void m_write(int idx, int s);
        e_we   = 1;
        m_addr = 9'((m_rd ? 0 : 256) + idx);
        m_data = 8'(((s >>> 10) & 255) ^ 128);
    endfunction

    function automatic void model_step(bit strb, int s, bit idle);
        bit real_t, to_t;
        e_we = 0; e_fd = 0;
        if (m_load) begin
            model_latch();
            m_load = 0;
        end
        if (m_written == NF) begin
            if (idle) begin
                m_rd = !m_rd; m_written = -1; m_primed = 0;
                model_latch();
            end
        end else if (m_written < 0) begin
            if (strb) begin
                real_t = m_primed && (c_fall ? (s <= c_lvl) : (s >= c_lvl));
                to_t   = c_aen && (m_tc == c_to);
                if (real_t || to_t) begin
                    m_write(0, s);
                    m_auto = !real_t; m_written = 1; m_since = 0;
                    m_primed = 0; m_tc = 0;
                    trig_strobes = 1; obs_writes = 0;
                end else begin
                    if (c_fall ? (s > c_lvl + c_hyst) : (s < c_lvl - c_hyst)) m_primed = 1;
                    m_tc = (m_tc + 1) % 65536;
                end
            end
        end else if (strb) begin
            m_since++; trig_strobes++;
            if (m_since % (c_dec + 1) == 0) begin
                m_write(m_written, s);
                m_written++;
                if (m_written == NF) e_fd = 1;
            end
        end
    endfunction

    function automatic int rnd(int lo, int hi);
        return lo + int'($urandom_range(hi - lo));
    endfunction

    task automatic step(input bit strb, input int s);
        new_sample_ready = strb;
        new_sample_in    = 18'(s);
        model_step(strb, s, wave_display_idle);
        @(posedge clk);
        #1;
        if (write_enable === 1'b1) obs_writes++;
        check("we", write_enable, e_we);
        check("frame_done", frame_done, e_fd);
        check("read_index", read_index, m_rd);
        check("auto_trig", auto_triggered, m_auto);
        check("wsample", write_sample, m_data);
        if (e_we) check("waddr", write_address, m_addr);
        if (e_fd) check("frame_len", obs_writes, NF);
        new_sample_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, write_enable, 0);
        check({tag, "_addr"}, write_address, 0);
        check({tag, "_data"}, write_sample, 0);
        check({tag, "_fd"}, frame_done, 0);
        check({tag, "_rd"}, read_index, 0);
        check({tag, "_auto"}, auto_triggered, 0);
    endtask

    task automatic set_cfg(input bit f, input int lvl, input int h, input int d, input bit ae, input int to);
        trig_falling = f; trig_level = 18'(lvl); trig_hyst = 18'(h);
        decim = 4'(d); auto_en = ae; auto_timeout = 16'(to);
    endtask

    task automatic swap();
        wave_display_idle = 1'b1;
        step(0, 0);
        wave_display_idle = 1'b0;
    endtask

    task automatic fill_frame(input int budget, input int p_strb);
        int n = 0;
        while (m_written > 0 && m_written < NF && n < budget) begin
            step($urandom_range(99) < p_strb, rnd(-3000, 3000));
            n++;
        end
        if (m_written != NF) check("fill_budget", m_written, NF);
    endtask

    // One random frame: random display idleness, occasional config churn while busy.
    task automatic rand_frame(input int budget);
        int  n = 0;
        bit  seen_fd = 0;
        while (n < budget && !(seen_fd && m_written < 0)) begin
            wave_display_idle = ($urandom_range(99) < 30);
            if ($urandom_range(99) < 5)
                set_cfg($urandom_range(1), rnd(-2000, 2000), rnd(0, 300), rnd(0, 3),
                        $urandom_range(1), rnd(0, 40));
            step($urandom_range(99) < 60, c_lvl + rnd(-3000, 3000));
            if (e_fd) seen_fd = 1;
            n++;
        end
        check("rand_frame_budget", seen_fd && m_written < 0, 1);
        wave_display_idle = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; new_sample_ready = 1'b0; new_sample_in = '0;
        wave_display_idle = 1'b0; obs_writes = 0; trig_strobes = 0;
        set_cfg(0, 0, 16, 0, 0, 0);
        model_reset();
        #12;
        check_all_zero("rst");
        @(posedge clk); #1;
        reset = 1'b1;

        // Rising edge, level 0, hysteresis 16, every sample kept.
        step(1, -100); step(0, 0); step(1, -5); step(1, 20);
        check("s1_first_we", write_enable, 1);
        check("s1_first_addr", write_address, 9'h100);
        check("s1_first_data", write_sample, 8'h80);
        for (int i = 1; i < NF; i++) step(1, i * 512 - 65536);
        check("s1_last_addr", write_address, 9'h1FF);
        check("s1_last_fd", frame_done, 1);
        for (int i = 0; i < 3; i++) step(0, 0);

        // Display busy: strobes in the pending-swap phase write nothing.
        for (int i = 0; i < 50; i++) step($urandom_range(1), rnd(-5000, 5000));
        set_cfg(0, 0, 16, 0, 0, 0);
        swap();
        check("s2_swap_rd", read_index, 1);
        step(1, -10); step(1, 5); step(1, -10); step(1, 5);
        check("s2_noise_we", write_enable, 0);
        step(1, -20); step(1, 3);
        check("s2_trig_we", write_enable, 1);
        check("s2_trig_addr", write_address, 9'h000);
        fill_frame(4000, 70);

        // Falling edge at 1000, keep one of every three strobes.
        set_cfg(1, 1000, 0, 2, 0, 0);
        swap();
        step(1, 2000); step(1, 900);
        check("s3_trig_we", write_enable, 1);
        fill_frame(4000, 100);
        check("s3_span", trig_strobes, 1 + 255 * 3);

        // Auto-trigger on the 11th strobe of a flat input.
        set_cfg(0, 0, 16, 0, 1, 10);
        swap();
        for (int k = 1; k <= 10; k++) step(1, 0);
        check("s4_no_early", write_enable, 0);
        step(1, 0);
        check("s4_auto_we", write_enable, 1);
        check("s4_auto_flag", auto_triggered, 1);
        fill_frame(4000, 80);
        swap();
        step(1, -100); step(1, 50);
        check("s4_real_we", write_enable, 1);
        check("s4_real_clear", auto_triggered, 0);
        fill_frame(4000, 80);
        swap();

        for (int f = 0; f < 5; f++) begin
            set_cfg($urandom_range(1), rnd(-2000, 2000), rnd(0, 300), rnd(0, 3),
                    $urandom_range(1), rnd(0, 40));
            rand_frame(8000);
        end

        // Abort a frame part way through with an asynchronous reset.
        n = 0;
        while (m_written != 100 && n < 8000) begin
            wave_display_idle = (m_written == NF);
            step(1, c_lvl + rnd(-3000, 3000));
            n++;
        end
        check("s6_reach_idx", m_written, 100);
        #3;
        reset = 1'b0;
        #1;
        check_all_zero("s6_async");
        model_reset();
        set_cfg(0, 500, 0, 1, 0, 0);
        @(posedge clk); #1;
        check_all_zero("s6_held");
        reset = 1'b1;
        for (int i = 0; i < 300; i++) begin
            wave_display_idle = $urandom_range(1);
            step($urandom_range(99) < 60, rnd(-2000, 3000));
        end
        wave_display_idle = 1'b0;
        rand_frame(8000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
